// File: rtl/goldschmidt_divider_core.sv
// Goldschmidt iteration engine: takes a seed from an external combinational LUT,
// then runs ITER multiplicative refinements to produce a Q16.16 quotient.
module goldschmidt_divider_core #(
    parameter int ITER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] N,
    input  logic [15:0] D,
    output logic [15:0] lut_D,
    input  logic [15:0] lut_Do,
    input  logic [3:0]  lut_C,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] Q
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    state_t      state;
    logic [15:0] n_r;
    logic [15:0] d_r;
    logic [31:0] nacc;
    logic [16:0] dacc;
    logic [3:0]  cnt;

    logic [17:0] f;
    logic [31:0] nacc_seed;
    logic [16:0] dacc_seed;
    logic [31:0] nacc_step;
    logic [16:0] dacc_step;

    assign lut_D = d_r;

    // F = 2 - Dacc in Q2.16; both products are truncated after the >>16.
    assign f         = 18'h20000 - {1'b0, dacc};
    assign nacc_seed = 32'(n_r) * 32'(lut_Do);
    assign dacc_seed = 17'(32'(d_r) * 32'(lut_Do));
    assign nacc_step = 32'((50'(nacc) * 50'(f)) >> 16);
    assign dacc_step = 17'((35'(dacc) * 35'(f)) >> 16);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulators are cleared as well so a reset mid-run leaves no stale partial result.
            state <= IDLE;
            n_r   <= '0;
            d_r   <= '0;
            nacc  <= '0;
            dacc  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            Q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r   <= N;
                        d_r   <= D;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    if (lut_C == 4'd0) begin
                        Q     <= '1;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        nacc  <= nacc_seed;
                        dacc  <= dacc_seed;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    nacc <= nacc_step;
                    dacc <= dacc_step;
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST_ITER) begin
                        Q     <= nacc_step;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_divider_core.sv
// Self-checking bench for goldschmidt_divider_core with a behavioural seed LUT
// and a plain-arithmetic quotient model.
module tb_goldschmidt_divider_core;

    localparam int ITER = 3;
    localparam int LAT  = ITER + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] N;
    logic [15:0] D;
    logic [15:0] lut_D;
    logic [15:0] lut_Do;
    logic [3:0]  lut_C;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] Q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    goldschmidt_divider_core #(.ITER(ITER)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .N      (N),
        .D      (D),
        .lut_D  (lut_D),
        .lut_Do (lut_Do),
        .lut_C  (lut_C),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .Q      (Q)
    );

    // Seed LUT: scale = ceil(0.75 / d) so d*scale lands at or just above 0.75.
    function automatic logic [15:0] lut_do_f(input logic [15:0] d);
        if (d < 16'd2 || d[15]) return 16'd0;
        return 16'((32'h0000C000 + 32'(d) - 32'd1) / 32'(d));
    endfunction

    function automatic logic [3:0] lut_c_f(input logic [15:0] d);
        int msb = 0;
        if (d < 16'd2 || d[15]) return 4'd0;
        for (int i = 0; i < 16; i++) if (d[i]) msb = i;
        return 4'(15 - msb);
    endfunction

    assign lut_Do = lut_do_f(lut_D);
    assign lut_C  = lut_c_f(lut_D);

    // Returns {err, Q} for one division.
    function automatic logic [32:0] ref_div(input logic [15:0] n, input logic [15:0] d);
        longint na;
        longint da;
        longint fm;
        if (lut_c_f(d) == 4'd0) return {1'b1, 32'hFFFF_FFFF};
        na = longint'(n) * longint'(lut_do_f(d));
        da = (longint'(d) * longint'(lut_do_f(d))) % 64'h20000;
        for (int k = 0; k < ITER; k++) begin
            fm = 64'h20000 - da;
            na = ((na * fm) >> 16) % 64'h1_0000_0000;
            da = ((da * fm) >> 16) % 64'h20000;
        end
        return {1'b0, 32'(na)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for IDLE, issues one start, returns the cycle of the done pulse
    // (accept cycle = 0) and busy as seen in cycle 1.
    task automatic run_div(input logic [15:0] n, input logic [15:0] d,
                           output int lat, output logic busy1);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        N = n;
        D = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy1 = busy;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        busy1;
        logic [31:0] q_hold;
        logic [32:0] r;
        logic [32:0] pend;
        int          prev_done;
        int          ndone;
        logic [15:0] dn;
        logic [15:0] dd;

        rst   = 1'b1;
        start = 1'b0;
        N     = '0;
        D     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_q",     Q,          32'd0);
        check("rst_lut_d", 32'(lut_D), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived quotients.
        run_div(16'h0064, 16'h0004, lat, busy1);
        check("d100_4_lat",  32'(lat),   32'(LAT));
        check("d100_4_busy", 32'(busy1), 32'd1);
        check("d100_4_q",    Q,          32'h0018_FFE7);
        check("d100_4_err",  32'(err),   32'd0);
        q_hold = Q;
        @(posedge clk);
        #1;
        check("hold_done", 32'(done), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_q",    Q,         q_hold);

        run_div(16'h8000, 16'h4000, lat, busy1);
        check("d8000_4000_q", Q, 32'h0001_FFFE);
        run_div(16'hFFFF, 16'h0002, lat, busy1);
        check("dffff_2_q",    Q, 32'h7FFF_0000);

        // Unsupported divisors.
        run_div(16'h1234, 16'h0000, lat, busy1);
        check("e0_lat", 32'(lat), 32'd2);
        check("e0_err", 32'(err), 32'd1);
        check("e0_q",   Q,        32'hFFFF_FFFF);
        run_div(16'h1234, 16'h0001, lat, busy1);
        check("e1_lat", 32'(lat), 32'd2);
        check("e1_err", 32'(err), 32'd1);
        check("e1_q",   Q,        32'hFFFF_FFFF);
        run_div(16'h1234, 16'h8000, lat, busy1);
        check("e8000_lat", 32'(lat), 32'd2);
        check("e8000_err", 32'(err), 32'd1);
        check("e8000_q",   Q,        32'hFFFF_FFFF);
        run_div(16'h1234, 16'h0010, lat, busy1);
        r = ref_div(16'h1234, 16'h0010);
        check("clr_err", 32'(err), 32'd0);
        check("clr_q",   Q,        r[31:0]);

        // start held high with fresh operands every cycle: only the pair present
        // in an IDLE cycle may be taken, and results come one per ITER+3 cycles.
        @(posedge clk);
        #1;
        pend      = '0;
        prev_done = -1;
        ndone     = 0;
        start     = 1'b1;
        for (int c = 0; c <= 5 * (ITER + 3); c++) begin
            @(negedge clk);
            dn = 16'($urandom);
            dd = 16'($urandom_range(2, 16'h7FFF));
            N  = dn;
            D  = dd;
            if (!busy) pend = ref_div(dn, dd);
            @(posedge clk);
            #1;
            if (done) begin
                check("held_q",   Q,        pend[31:0]);
                check("held_err", 32'(err), 32'(pend[32]));
                if (prev_done >= 0) check("held_gap", 32'(c - prev_done), 32'(ITER + 3));
                prev_done = c;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_count", 32'(ndone), 32'd5);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_drain_q", Q, pend[31:0]);

        // Reset during the second RUN cycle.
        @(negedge clk);
        while (busy) @(negedge clk);
        N = 16'h0200;
        D = 16'h0007;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q",    Q,         32'd0);
        check("mid_rst_err",  32'(err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(16'h0200, 16'h0007, lat, busy1);
        r = ref_div(16'h0200, 16'h0007);
        check("post_rst_lat", 32'(lat), 32'(LAT));
        check("post_rst_q",   Q,        r[31:0]);

        // Random vectors against the model.
        for (int v = 0; v < 3000; v++) begin
            dn = 16'($urandom);
            dd = 16'($urandom_range(2, 16'h7FFF));
            r  = ref_div(dn, dd);
            run_div(dn, dd, lat, busy1);
            check("rand_q", Q, r[31:0]);
            if (v % 100 == 0) begin
                check("rand_lat", 32'(lat), 32'(LAT));
                check("rand_err", 32'(err), 32'(r[32]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
